// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the alignment rule.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Reserved size counts as misaligned so a single check flags it.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables/replicated write data, and
// load extraction with zero/sign extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_c,
  output logic [31:0] wword_c,
  output logic [31:0] rdata_c
);

  logic [31:0] rshift;
  logic [15:0] rhalf;

  assign rshift = rword_i >> {addr_lo_i, 3'b000};
  assign rhalf  = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Store path: data is replicated across lanes, enables pick the live ones.
  always_comb begin
    be_c    = 4'b0000;
    wword_c = 32'h0;
    case (size_i)
      SIZE_BYTE: begin
        be_c    = 4'(4'b0001 << addr_lo_i);
        wword_c = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_c    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{wdata_i[15:0]}};
      end
      SIZE_WORD: begin
        be_c    = 4'b1111;
        wword_c = wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_c = 32'h0;
    case (size_i)
      SIZE_BYTE: rdata_c = signed_i ? {{24{rshift[7]}}, rshift[7:0]} : {24'h0, rshift[7:0]};
      SIZE_HALF: rdata_c = signed_i ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      SIZE_WORD: rdata_c = rword_i;
      default:   rdata_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multicycle data-memory responder: valid/ready request and response channels,
// programmable wait states, byte/halfword/word accesses with error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, rsp_valid_q, rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic          we_q, signed_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q;

  logic [31:0]   mem_q [DEPTH];

  logic          accept_c, commit_c, in_range_c, err_c, mem_we_c;
  logic [AW-1:0] idx_c;
  logic [31:0]   rword_c, wword_c, ldata_c;
  logic [3:0]    be_c;

  assign in_range_c = (addr_q[31:2] < 30'(DEPTH));
  assign idx_c      = addr_q[AW+1:2];
  assign rword_c    = in_range_c ? mem_q[idx_c] : 32'h0;
  assign err_c      = misaligned(size_q, addr_q[1:0]) || !in_range_c;
  assign mem_we_c   = commit_c && we_q && !err_c;

  dmem_lane_align u_align (
    .size_i    (size_q),
    .signed_i  (signed_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (rword_c),
    .be_c      (be_c),
    .wword_c   (wword_c),
    .rdata_c   (ldata_c)
  );

  // Next-state, counter and response data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept_c    = 1'b0;
    commit_c    = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          accept_c = 1'b1;
          cnt_d    = CW'(WAIT_CYCLES);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit_c    = 1'b1;
          rsp_err_d   = err_c;
          rsp_rdata_d = (err_c || we_q) ? 32'h0 : ldata_c;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= SIZE_BYTE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      if (accept_c) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Storage keeps its contents across reset; writes gate on the commit edge only.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wword_c[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the ARM core's load/store port.
- Serves word, halfword and byte accesses (LDR/STR/LDRB/STRB/LDRH/STRH/LDRSB/LDRSH) over a valid/ready request channel and a valid/ready response channel.
- Inserts a configurable number of wait states per access to model slow memory.
- Replaces the zero-latency dmem when the core moves to a multicycle/stall-capable memory interface.

Parameters:
- DEPTH, 64, number of 32-bit words of storage; word index = req_addr[31:2].
- WAIT_CYCLES, 2, extra wait states between request acceptance and the memory access; 0..15 legal.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  in  1  loads only: sign-extend byte/halfword.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  misaligned, reserved size, or out-of-range access.

Behaviour:
- Reset: state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not reset.
- req_ready is registered. It rises on the first clk edge after reset deasserts and is 1 exactly when state==IDLE.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Handshake at an edge with req_valid & req_ready latches we/size/signed/addr/wdata.
  - Counter loads WAIT_CYCLES; state goes to WAIT; req_ready drops.
  - req_* is ignored when req_ready=0.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0, the access commits:
    - Store: writes the enabled byte lanes.
    - Load: rsp_rdata is registered from the current memory word.
    - rsp_err is registered.
    - State goes to RESP.
- Latency: with accept at edge E0, rsp_valid is high after edge E0+WAIT_CYCLES+1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - At an edge with rsp_valid & rsp_ready: state goes to IDLE, rsp_valid=0, req_ready=1.
- Lane rules (little-endian):
  - Byte uses lane addr[1:0].
  - Halfword uses lanes {addr[1],0} and {addr[1],1}.
  - Word uses all four lanes.
  - Loads extract the lane(s) to [7:0]/[15:0], then zero-extend, or sign-extend if req_signed. Word loads ignore req_signed.
- Errors (rsp_err=1, no write performed, rsp_rdata=0):
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - req_size=11.
  - addr[31:2] >= DEPTH.
- Ordering: accesses commit in acceptance order; a load after a store to the same word returns the stored data.
- Reset mid-operation: any pending request is dropped. A store whose commit edge has not occurred is never written. Outputs return to reset values immediately.
- Simultaneous events: req_valid asserted in RESP is not accepted. The earliest new acceptance is the edge after rsp handshake + 1. Minimum period is WAIT_CYCLES+3 cycles per request with rsp_ready tied high.

Decomposition:
- Shared package dmem_pkg holds:
  - SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_RSVD=2'b11.
  - The state enum {IDLE, WAIT, RESP}.
  - A misalignment-check function.
- One sub-module, dmem_lane_align (combinational):
  - Store path: produces 4-bit byte enables and the lane-shifted write word from size/addr[1:0]/wdata.
  - Load path: extracts and extends read data from size/signed/addr[1:0]/word.
- Storage array, counter and FSM live in dmem_responder.

Test Plan:
- Word store/load, WAIT_CYCLES=2:
  - Store 0x00000007 to addr 100; rsp_valid rises 3 edges after accept with rsp_err=0.
  - Load addr 100 returns rsp_rdata=0x00000007.
- Byte lanes:
  - Store word 0x11223344 at addr 96; byte-store 0xAB to addr 98.
  - Word load of 96 returns 0x11AB3344.
  - Load byte signed at 98 returns 0xFFFFFFAB; load byte unsigned at 98 returns 0x000000AB.
- Halfword:
  - Store 0x8001 to addr 102.
  - LDRSH 102 returns 0xFFFF8001; LDRH 102 returns 0x00008001.
  - Word at 100 upper half is 0x8001.
- Errors:
  - Word load at addr 101 gives rsp_err=1, rsp_rdata=0.
  - Halfword store at 97 gives rsp_err=1 and memory is unchanged.
  - Load at addr 256 (DEPTH=64) gives rsp_err=1.
  - req_size=11 gives rsp_err=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles; rsp_valid, rsp_rdata and rsp_err stay constant, req_ready stays 0, and a req_valid pulse is ignored.
  - Release rsp_ready; req_ready returns to 1 one edge later.
- Reset mid-op:
  - Accept a store of 0xDEADBEEF to addr 4; assert reset during WAIT.
  - After reset, a load of addr 4 returns its prior value of 0x00000000, written before the test.
  - Outputs were at reset values throughout reset.
